// File: rtl/game_pkg.sv
// Shared types and constants for the tic-tac-toe board controller.
package game_pkg;

  localparam int         NUM_SQUARES = 9;
  localparam int         NUM_LINES   = 8;
  localparam logic [8:0] FULL_BOARD  = 9'h1FF;

  typedef enum logic [1:0] {
    RESP_OK       = 2'b00,
    RESP_OCCUPIED = 2'b01,
    RESP_RANGE    = 2'b10,
    RESP_OVER     = 2'b11
  } resp_code_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_A    = 2'b01,
    WIN_B    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    ST_PLAY = 2'b00,
    ST_EVAL = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  // Keeps only the least-significant set bit of a line vector.
  function automatic logic [NUM_LINES-1:0] lowest_bit(input logic [NUM_LINES-1:0] v);
    return v & (~v + 8'd1);
  endfunction

endpackage

// File: rtl/game_board_ctrl_detect_winner.sv
// DetectWinner: one-hot three-in-a-row detector; bit 8 is top-left, bit 0 bottom-right.
module DetectWinner
  import game_pkg::*;
(
  input  logic [8:0] ain,
  input  logic [8:0] bin,
  output logic [7:0] win_line
);

  // Line order: rows top..bottom, columns left..right, then the two diagonals.
  function automatic logic [7:0] lines_of(input logic [8:0] p);
    return {p[6] & p[4] & p[2],
            p[8] & p[4] & p[0],
            p[6] & p[3] & p[0],
            p[7] & p[4] & p[1],
            p[8] & p[5] & p[2],
            p[2] & p[1] & p[0],
            p[5] & p[4] & p[3],
            p[8] & p[7] & p[6]};
  endfunction

  assign win_line = lowest_bit(lines_of(ain) | lines_of(bin));

endmodule

// File: rtl/game_board_ctrl.sv
// Tic-tac-toe move controller: validates moves, keeps the board and decides the game result.
module game_board_ctrl
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic       resp_valid,
  output logic [1:0] resp_code,
  output logic [8:0] ain,
  output logic [8:0] bin,
  output logic       turn,
  output logic [3:0] move_count,
  output logic [7:0] win_line,
  output logic [1:0] winner,
  output logic       game_over
);

  state_e     r_state;
  state_e     w_state_next;
  logic [8:0] r_ain;
  logic [8:0] r_bin;
  logic       r_turn;
  logic [3:0] r_move_count;
  logic [7:0] r_win_line;
  winner_e    r_winner;
  logic       r_resp_valid;
  logic [1:0] r_resp_code;

  logic       w_hs;
  logic [8:0] w_pos_mask;
  logic       w_occupied;
  resp_code_e w_code;
  logic       w_accept;
  logic [7:0] w_det_line;
  winner_e    w_eval_winner;

  DetectWinner u_detect (
    .ain      (r_ain),
    .bin      (r_bin),
    .win_line (w_det_line)
  );

  assign move_ready = (r_state != ST_EVAL);
  assign game_over  = (r_winner != WIN_NONE);
  assign w_hs       = move_valid & move_ready;
  assign w_pos_mask = 9'b1 << move_pos;
  assign w_occupied = |((r_ain | r_bin) & w_pos_mask);
  assign w_accept   = w_hs & ~new_game & (w_code == RESP_OK);

  // Response classification in priority order.
  always_comb begin
    w_code = RESP_OK;
    if (r_winner != WIN_NONE) begin
      w_code = RESP_OVER;
    end else if (move_pos > 4'd8) begin
      w_code = RESP_RANGE;
    end else if (w_occupied) begin
      w_code = RESP_OCCUPIED;
    end else begin
      w_code = RESP_OK;
    end
  end

  // Result of the evaluation cycle; turn has already flipped, so the last mover is ~r_turn.
  always_comb begin
    w_eval_winner = WIN_NONE;
    if (r_winner != WIN_NONE) begin
      w_eval_winner = r_winner;
    end else if (w_det_line != 8'h00) begin
      w_eval_winner = r_turn ? WIN_A : WIN_B;
    end else if ((r_ain | r_bin) == FULL_BOARD) begin
      w_eval_winner = WIN_DRAW;
    end else begin
      w_eval_winner = WIN_NONE;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    if (new_game) begin
      w_state_next = ST_PLAY;
    end else begin
      case (r_state)
        ST_PLAY: w_state_next = w_hs ? ST_EVAL : ST_PLAY;
        ST_EVAL: w_state_next = (w_eval_winner != WIN_NONE) ? ST_OVER : ST_PLAY;
        ST_OVER: w_state_next = w_hs ? ST_EVAL : ST_OVER;
        default: w_state_next = ST_PLAY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_PLAY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Board, score and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ain        <= 9'h000;
      r_bin        <= 9'h000;
      r_turn       <= 1'b0;
      r_move_count <= 4'd0;
      r_win_line   <= 8'h00;
      r_winner     <= WIN_NONE;
      r_resp_valid <= 1'b0;
      r_resp_code  <= 2'b00;
    end else begin
      r_resp_valid <= w_hs & ~new_game;
      if (w_hs & ~new_game) begin
        r_resp_code <= w_code;
      end
      if (new_game) begin
        r_ain        <= 9'h000;
        r_bin        <= 9'h000;
        r_turn       <= 1'b0;
        r_move_count <= 4'd0;
        r_win_line   <= 8'h00;
        r_winner     <= WIN_NONE;
      end else begin
        if (w_accept) begin
          if (r_turn) begin
            r_bin <= r_bin | w_pos_mask;
          end else begin
            r_ain <= r_ain | w_pos_mask;
          end
          r_turn       <= ~r_turn;
          r_move_count <= r_move_count + 4'd1;
        end
        if (r_state == ST_EVAL) begin
          r_win_line <= w_det_line;
          r_winner   <= w_eval_winner;
        end
      end
    end
  end

  assign ain        = r_ain;
  assign bin        = r_bin;
  assign turn       = r_turn;
  assign move_count = r_move_count;
  assign win_line   = r_win_line;
  assign winner     = r_winner;
  assign resp_valid = r_resp_valid;
  assign resp_code  = r_resp_code;

endmodule

// File: tb/tb_game_board_ctrl.sv
// Scoreboard bench for game_board_ctrl: directed games plus short random games.
module tb_game_board_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic       resp_valid;
  logic [1:0] resp_code;
  logic [8:0] ain;
  logic [8:0] bin;
  logic       turn;
  logic [3:0] move_count;
  logic [7:0] win_line;
  logic [1:0] winner;
  logic       game_over;

  game_board_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .move_ready (move_ready),
    .resp_valid (resp_valid),
    .resp_code  (resp_code),
    .ain        (ain),
    .bin        (bin),
    .turn       (turn),
    .move_count (move_count),
    .win_line   (win_line),
    .winner     (winner),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  logic [8:0] m_ain;
  logic [8:0] m_bin;
  logic       m_turn;
  logic [3:0] m_count;
  logic [7:0] m_line;
  logic [1:0] m_winner;

  // Winning triples, 8 = top-left: rows, columns, diagonals.
  localparam int LN [8][3] = '{'{8, 7, 6}, '{5, 4, 3}, '{2, 1, 0},
                               '{8, 5, 2}, '{7, 4, 1}, '{6, 3, 0},
                               '{8, 4, 0}, '{6, 4, 2}};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_line(input logic [8:0] a, input logic [8:0] b);
    for (int i = 0; i < 8; i++) begin
      if ((a[LN[i][0]] && a[LN[i][1]] && a[LN[i][2]]) ||
          (b[LN[i][0]] && b[LN[i][1]] && b[LN[i][2]]))
        return 8'(1 << i);
    end
    return 8'h00;
  endfunction

  task automatic model_clear();
    m_ain = 9'h000; m_bin = 9'h000; m_turn = 1'b0;
    m_count = 4'd0; m_line = 8'h00; m_winner = 2'b00;
  endtask

  // Scoreboard: every response pulse pops one expected code.
  always @(negedge clk) begin : mon
    logic [1:0] e;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("resp_without_move", 32'(resp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("resp_code", 32'(resp_code), 32'(e));
      end
    end
  end

  task automatic check_board(input string tag);
    check_val({tag, "_ain"},   32'(ain),        32'(m_ain));
    check_val({tag, "_bin"},   32'(bin),        32'(m_bin));
    check_val({tag, "_turn"},  32'(turn),       32'(m_turn));
    check_val({tag, "_count"}, 32'(move_count), 32'(m_count));
  endtask

  task automatic check_result(input string tag);
    check_val({tag, "_win_line"},  32'(win_line),  32'(m_line));
    check_val({tag, "_winner"},    32'(winner),    32'(m_winner));
    check_val({tag, "_game_over"}, 32'(game_over), 32'(m_winner != 2'b00));
  endtask

  task automatic check_reset(input string tag);
    check_board(tag);
    check_result(tag);
    check_val({tag, "_ready"},      32'(move_ready), 32'd1);
    check_val({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_val({tag, "_resp_code"},  32'(resp_code),  32'd0);
  endtask

  // Drives one handshake; returns at the negedge of the evaluation cycle.
  task automatic handshake_only(input logic [3:0] pos);
    logic [1:0] code;
    logic [8:0] mask;
    int w;
    w = 0;
    mask = 9'h000;
    while (move_ready !== 1'b1 && w < 8) begin
      @(negedge clk);
      w++;
    end
    check_val("ready_before_move", 32'(move_ready), 32'd1);
    if (m_winner != 2'b00) code = 2'b11;
    else if (pos > 4'd8) code = 2'b10;
    else begin
      mask = 9'd1 << pos;
      code = (((m_ain | m_bin) & mask) != 9'h000) ? 2'b01 : 2'b00;
    end
    if (code == 2'b00) begin
      if (m_turn) m_bin = m_bin | mask;
      else        m_ain = m_ain | mask;
      m_turn  = ~m_turn;
      m_count = m_count + 4'd1;
    end
    exp_q.push_back(code);
    move_valid = 1'b1;
    move_pos   = pos;
    @(negedge clk);
    move_valid = 1'b0;
    move_pos   = 4'd0;
    check_val("resp_valid_after_move", 32'(resp_valid), 32'd1);
    check_val("busy_in_eval", 32'(move_ready), 32'd0);
  endtask

  task automatic do_move(input logic [3:0] pos);
    handshake_only(pos);
    check_board("eval");
    @(negedge clk);
    if (m_winner == 2'b00) begin
      m_line = model_line(m_ain, m_bin);
      if (m_line != 8'h00) m_winner = m_turn ? 2'b01 : 2'b10;
      else if ((m_ain | m_bin) == 9'h1FF) m_winner = 2'b11;
      else m_winner = 2'b00;
    end
    check_val("ready_after_eval", 32'(move_ready), 32'd1);
    check_val("resp_valid_idle", 32'(resp_valid), 32'd0);
    check_result("post_eval");
  endtask

  task automatic start_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
    check_board("new_game");
    check_result("new_game");
  endtask

  initial begin
    rst = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    // First move in the centre.
    do_move(4'd4);
    check_val("first_ain", 32'(ain), 32'h010);
    check_val("first_turn", 32'(turn), 32'd1);
    check_val("first_count", 32'(move_count), 32'd1);

    // A takes the top row.
    start_new_game();
    do_move(4'd8); do_move(4'd0); do_move(4'd7); do_move(4'd1); do_move(4'd6);
    check_val("row_win_line", 32'(win_line), 32'h01);
    check_val("row_winner", 32'(winner), 32'd1);
    check_val("row_game_over", 32'(game_over), 32'd1);
    do_move(4'd5);
    check_val("over_ain", 32'(ain), 32'h1C0);
    check_val("over_bin", 32'(bin), 32'h003);

    // new_game while evaluating.
    start_new_game();
    handshake_only(4'd2);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
    check_board("ng_eval");
    check_val("ng_eval_ready", 32'(move_ready), 32'd1);
    check_val("ng_eval_winner", 32'(winner), 32'd0);

    // Occupied and out-of-range squares.
    do_move(4'd4); do_move(4'd4); do_move(4'd9); do_move(4'd15);
    check_val("reject_turn", 32'(turn), 32'd1);
    check_val("reject_count", 32'(move_count), 32'd1);

    // new_game together with a move.
    new_game = 1'b1; move_valid = 1'b1; move_pos = 4'd3;
    @(negedge clk);
    new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
    model_clear();
    check_board("ng_move");
    check_val("ng_move_resp", 32'(resp_valid), 32'd0);
    check_val("ng_move_ready", 32'(move_ready), 32'd1);
    @(negedge clk);
    check_val("ng_move_resp_late", 32'(resp_valid), 32'd0);

    // Full board with no line.
    do_move(4'd8); do_move(4'd7); do_move(4'd6); do_move(4'd4); do_move(4'd3);
    do_move(4'd0); do_move(4'd1); do_move(4'd2); do_move(4'd5);
    check_val("draw_winner", 32'(winner), 32'd3);
    check_val("draw_line", 32'(win_line), 32'd0);
    check_val("draw_count", 32'(move_count), 32'd9);
    check_val("draw_full", 32'(ain | bin), 32'h1FF);
    do_move(4'd0);

    // Random games.
    for (int g = 0; g < 4; g++) begin
      start_new_game();
      for (int k = 0; k < 25 && m_winner == 2'b00; k++) begin
        do_move(4'($urandom_range(0, 10)));
      end
    end

    // Reset during evaluation.
    start_new_game();
    do_move(4'd1);
    handshake_only(4'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_reset("rst_eval");

    @(negedge clk);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/game_board_ctrl.md
GAME_BOARD_CTRL -- requirements
Module: game_board_ctrl

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 new_game  in  1  clears the board and game state at the next edge.
REQ-005 move_valid  in  1  move request from the current player.
REQ-006 move_pos  in  4  target square, 0..8, using the DetectWinner bit numbering (8 = top-left, 0 = bottom-right).
REQ-007 move_ready  out  1  the block can accept a move this cycle.
REQ-008 resp_valid  out  1  one-cycle response pulse.
REQ-009 resp_code  out  2  response code: 00 accepted, 01 occupied, 10 position out of range, 11 game over.
REQ-010 ain, bin  out  9 each  registered board for player A and player B.
REQ-011 turn  out  1  player to move next: 0 = A, 1 = B.
REQ-012 move_count  out  4  number of accepted moves, 0..9.
REQ-013 win_line  out  8  registered one-hot winning line in DetectWinner encoding; 0 = no win.
REQ-014 winner  out  2  game result: 00 none, 01 A, 10 B, 11 draw.
REQ-015 game_over  out  1  high when winner != 00.

Function
REQ-016 State machine states SHALL be PLAY, EVAL and OVER.
REQ-017 A handshake SHALL occur when move_valid && move_ready.
REQ-018 move_ready SHALL be 1 in PLAY and OVER, and 0 in EVAL.
REQ-019 Every handshake at edge T SHALL move the FSM to EVAL and drive resp_valid=1 with resp_code during cycle T+1.
REQ-020 Response priority SHALL be: game over (11), then move_pos > 8 (10), then square occupied in ain|bin (01), then accepted (00).
REQ-021 An accepted move SHALL, at edge T:
- set bit move_pos of ain (turn=0) or bin (turn=1);
- toggle turn;
- increment move_count.
REQ-022 A rejected move SHALL leave the board, turn and move_count unchanged.
REQ-023 In EVAL, the win check SHALL use the registered ain/bin. At edge T+2 the block SHALL:
- register win_line;
- set winner to the last mover when win_line != 0;
- else set winner to 11 when ain|bin == 9'h1FF;
- go to OVER if winner != 00, otherwise go to PLAY.
REQ-024 The handshake-to-next-ready latency SHALL be exactly 2 cycles, giving at most one move per 2 cycles.
REQ-025 In OVER, every handshake SHALL be answered with code 11 via EVAL, and the FSM SHALL return to OVER.
REQ-026 When a win exists on multiple lines, win_line SHALL hold the lowest-index bit only, per the DetectWinner priority.
REQ-027 new_game SHALL clear ain, bin, turn, move_count, win_line and winner and enter PLAY at the next edge, in any state.
- new_game has priority over a simultaneous handshake: that move is ignored and produces no response.
- A resp_valid pulse already driven in the same cycle stands.
REQ-028 resp_valid SHALL be 0 in every cycle not immediately following a handshake.

Reset
REQ-029 On rst: state=PLAY, ain=bin=0, turn=0, move_count=0, win_line=0, winner=00, resp_valid=0, resp_code=00.
REQ-030 rst SHALL have priority over new_game and over any handshake.

Structure
REQ-031 A shared package game_pkg SHALL hold:
- NUM_SQUARES=9;
- FULL_BOARD=9'h1FF;
- the resp_code enum;
- the winner enum;
- the FSM state enum.
REQ-032 The block SHALL instantiate the existing DetectWinner as its only sub-module, fed from the registered ain/bin.
REQ-033 All outputs SHALL be registered except move_ready and game_over, which are decoded from registered state.

Verification
REQ-034 Reset then move_pos=4 -> at T+1: resp 00, ain=9'h010, turn=1, move_count=1; at T+2: move_ready=1.
REQ-035 A plays 8,7,6 and B plays 0,1 (alternating) -> after the fifth accept plus 2 cycles: win_line=8'h01, winner=01, game_over=1; a further move returns resp 11 with the board unchanged.
REQ-036 Move to an occupied square, then move_pos=9 -> resp 01, then resp 10; turn and move_count unchanged.
REQ-037 Nine moves with no line (A:8,6,3,1,5; B:7,4,0,2) -> winner=11, win_line=0, move_count=9, ain|bin=9'h1FF.
REQ-038 new_game asserted in EVAL, and separately together with move_valid in PLAY -> board cleared, turn=0, state PLAY; no resp for the simultaneous move.
REQ-039 rst asserted mid-game in EVAL -> all outputs at their reset values on the next cycle.
